// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch initiator for a 6502-style core. It owns the program
//   counter and reads three bytes at the PC from a single-port byte memory
//   with one-cycle registered read latency. It decodes the instruction length
//   from the opcode and offers {op2, op1, opcode} to decode through a
//   valid/ready handshake. Single-byte stores from execute share the same
//   memory port. Branch/jump redirects reload the PC from any state.
//
// Ports
//   clk_i, rst_i        clock; asynchronous active-high reset
//   mem_addr_o          memory address (store address when granted, else PC)
//   mem_data_o          store byte
//   mem_we_o            memory write enable
//   mem_data_i          read data {addr+2, addr+1, addr}, one cycle after addr
//   instr_valid_o       instruction available to decode
//   instr_ready_i       decode accepts the instruction
//   instr_o             {op2, op1, opcode}
//   instr_len_o         instruction length, 1..3
//   instr_pc_o          address of the opcode
//   redirect_i          load redirect_pc_i into the PC (highest priority)
//   redirect_pc_i       new PC
//   st_req_i            store request, held until st_gnt_o
//   st_addr_i           store address
//   st_data_i           store byte
//   st_gnt_o            store issued on the memory port this cycle
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int          MEM_ADDR_SIZE = 16,
  parameter int unsigned RESET_PC      = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
  output logic [7:0]               mem_data_o,
  output logic                     mem_we_o,
  input  logic [23:0]              mem_data_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [23:0]              instr_o,
  output logic [1:0]               instr_len_o,
  output logic [MEM_ADDR_SIZE-1:0] instr_pc_o,
  input  logic                     redirect_i,
  input  logic [MEM_ADDR_SIZE-1:0] redirect_pc_i,
  input  logic                     st_req_i,
  input  logic [MEM_ADDR_SIZE-1:0] st_addr_i,
  input  logic [7:0]               st_data_i,
  output logic                     st_gnt_o
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // address the opcode (or issue a store)
    S_RSP   = 2'd1,  // read data for pc is on mem_data_i
    S_VALID = 2'd2   // instruction presented to decode
  } state_t;

  state_t                   state;
  logic [MEM_ADDR_SIZE-1:0] pc;
  logic                     store_slot;

  // 6502 length decode, grouped by the cc column of the opcode matrix.
  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [1:0] cc;
    logic [2:0] bbb;
    logic [2:0] aaa;
    cc  = op[1:0];
    bbb = op[4:2];
    aaa = op[7:5];
    decode_len = 2'd1;
    case (cc)
      2'b01: begin
        if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) decode_len = 2'd3;
        else                                                  decode_len = 2'd2;
      end
      2'b10: begin
        case (bbb)
          3'b000, 3'b001, 3'b101: decode_len = 2'd2;
          3'b011, 3'b111:         decode_len = 2'd3;
          default:                decode_len = 2'd1;
        endcase
      end
      2'b00: begin
        if (bbb == 3'b000) begin
          // Column 0 mixes implied (BRK/RTI/RTS), JSR absolute and immediates.
          if (aaa == 3'b001)     decode_len = 2'd3;
          else if (aaa >= 3'b101) decode_len = 2'd2;
          else                    decode_len = 2'd1;
        end else begin
          case (bbb)
            3'b001, 3'b100, 3'b101: decode_len = 2'd2;
            3'b011, 3'b111:         decode_len = 2'd3;
            default:                decode_len = 2'd1;
          endcase
        end
      end
      default: decode_len = 2'd1;  // cc=11 is illegal on the 6502
    endcase
  endfunction

  // The port is free for a store while no read response is pending.
  assign store_slot = (state == S_REQ) || (state == S_VALID);

  // NOTE: every combinational output gets a default before any condition so
  // no path leaves it unassigned (which would infer a latch).
  always_comb begin
    st_gnt_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = pc;
    mem_data_o = 8'h00;
    // Grant and write enable are held off while reset is asserted so a stray
    // store request cannot corrupt memory during reset.
    if (!rst_i && st_req_i && store_slot) begin
      st_gnt_o   = 1'b1;
      mem_we_o   = 1'b1;
      mem_addr_o = st_addr_i;
      mem_data_o = st_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the later redirect override is clean.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_REQ;
      pc            <= MEM_ADDR_SIZE'(RESET_PC);
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      instr_len_o   <= '0;
      instr_pc_o    <= '0;
    end else begin
      case (state)
        S_REQ: begin
          // A store occupies the port; the fetch read waits a cycle.
          if (!st_req_i) state <= S_RSP;
        end
        S_RSP: begin
          instr_o       <= mem_data_i;
          instr_pc_o    <= pc;
          instr_len_o   <= decode_len(mem_data_i[7:0]);
          instr_valid_o <= 1'b1;
          state         <= S_VALID;
        end
        S_VALID: begin
          if (instr_ready_i) begin
            pc            <= pc + MEM_ADDR_SIZE'(instr_len_o);
            instr_valid_o <= 1'b0;
            state         <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase

      // Redirect wins over the sequential PC update; a coincident handshake
      // still consumes the instruction because valid drops either way.
      if (redirect_i) begin
        pc            <= redirect_pc_i;
        instr_valid_o <= 1'b0;
        state         <= S_REQ;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A byte-array memory with a one-cycle
//   registered read feeds the DUT. The expected instruction stream comes from
//   a PC model that walks that same memory, with lengths taken from lookup
//   tables of the 6502 opcode matrix.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic        mem_we_o;
  logic [23:0] mem_data_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [23:0] instr_o;
  logic [1:0]  instr_len_o;
  logic [15:0] instr_pc_o;
  logic        redirect_i = 1'b0;
  logic [15:0] redirect_pc_i = '0;
  logic        st_req_i = 1'b0;
  logic [15:0] st_addr_i = '0;
  logic [7:0]  st_data_i = '0;
  logic        st_gnt_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] model_pc;

  logic [7:0] mem [65536];

  // Length per addressing-mode column, indexed by bbb; column cc=00/bbb=000
  // is indexed by aaa instead.
  int len_cc01 [8] = '{2, 2, 2, 3, 2, 2, 3, 3};
  int len_cc10 [8] = '{2, 2, 1, 3, 1, 2, 1, 3};
  int len_cc00 [8] = '{0, 2, 1, 3, 2, 2, 1, 3};
  int len_col0 [8] = '{1, 3, 1, 1, 1, 2, 2, 2};

  fetch_unit #(.MEM_ADDR_SIZE(16), .RESET_PC(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
    .mem_data_i(mem_data_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_len_o(instr_len_o), .instr_pc_o(instr_pc_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
    .st_gnt_o(st_gnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory: byte writes, registered 3-byte read with address wrap.
  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_addr_o] <= mem_data_o;
    mem_data_i <= {mem[mem_addr_o + 16'd2], mem[mem_addr_o + 16'd1], mem[mem_addr_o]};
  end

  function automatic logic [1:0] ref_len(input logic [7:0] op);
    int n;
    case (op[1:0])
      2'b01:   n = len_cc01[op[4:2]];
      2'b10:   n = len_cc10[op[4:2]];
      2'b00:   n = (op[4:2] == 3'd0) ? len_col0[op[7:5]] : len_cc00[op[4:2]];
      default: n = 1;
    endcase
    return 2'(n);
  endfunction

  function automatic logic [23:0] ref_instr(input logic [15:0] a);
    logic [15:0] a1, a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    return {mem[a2], mem[a1], mem[a]};
  endfunction

  // All bench activity happens 1 time unit after a falling edge.
  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit found, output int cycles);
    found  = 1'b0;
    cycles = 0;
    for (int n = 0; n < max_cycles; n++) begin
      cycles = n + 1;
      if (instr_valid_o) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Waits for an instruction, records it and completes the handshake.
  task automatic take(output bit found, output int cycles, output logic [23:0] ins,
                      output logic [1:0] len, output logic [15:0] ipc);
    wait_valid(20, found, cycles);
    ins = instr_o;
    len = instr_len_o;
    ipc = instr_pc_o;
    if (found) begin
      instr_ready_i = 1'b1;
      step();
      instr_ready_i = 1'b0;
    end
  endtask

  task automatic do_redirect(input logic [15:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    step();
    redirect_i = 1'b0;
    model_pc   = target;
  endtask

  task automatic test_reset();
    bit found; int cyc; logic [23:0] ins; logic [1:0] len; logic [15:0] ipc;
    mem[0] <= 8'h09; mem[1] <= 8'h01; mem[2] <= 8'h01;
    mem[3] <= 8'h05; mem[4] <= 8'h04; mem[5] <= 8'h04;
    rst_i    = 1'b1;
    st_req_i = 1'b1;
    st_addr_i = 16'h0040;
    step(); step();
    total++;
    if (instr_valid_o !== 1'b0 || instr_o !== 24'h0 || instr_len_o !== 2'd0 ||
        instr_pc_o !== 16'h0 || mem_we_o !== 1'b0 || st_gnt_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: valid=%b instr=%h len=%0d pc=%h we=%b gnt=%b, want all zero",
               instr_valid_o, instr_o, instr_len_o, instr_pc_o, mem_we_o, st_gnt_o);
    end
    st_req_i = 1'b0;
    rst_i    = 1'b0;
    model_pc = 16'h0000;
    take(found, cyc, ins, len, ipc);
    total++;
    if (!found || cyc !== 3 || ins !== 24'h010109 || len !== 2'd2 || ipc !== 16'h0000) begin
      bad++;
      $display("FAIL first_fetch: found=%b cycle=%0d instr=%h len=%0d pc=%h, want cycle=3 instr=010109 len=2 pc=0000",
               found, cyc, ins, len, ipc);
    end
    take(found, cyc, ins, len, ipc);
    total++;
    if (!found || cyc !== 3 || ins[7:0] !== 8'h01 || len !== 2'd2 || ipc !== 16'h0002) begin
      bad++;
      $display("FAIL second_fetch: found=%b cycle=%0d opcode=%h len=%0d pc=%h, want cycle=3 opcode=01 len=2 pc=0002",
               found, cyc, ins[7:0], len, ipc);
    end
    model_pc = 16'h0004;
  endtask

  task automatic test_lengths();
    bit found; int cyc; logic [23:0] ins; logic [1:0] len; logic [15:0] ipc;
    logic [7:0]  ops [8];
    logic [1:0]  want_len [8];
    logic [15:0] a;
    ops      = '{8'hEA, 8'h15, 8'hAD, 8'h20, 8'h60, 8'hA2, 8'hF0, 8'hFF};
    want_len = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd2, 2'd1};
    a = 16'h0200;
    for (int i = 0; i < 8; i++) begin
      mem[a] <= ops[i];
      a = a + 16'(want_len[i]);
    end
    do_redirect(16'h0200);
    for (int i = 0; i < 8; i++) begin
      take(found, cyc, ins, len, ipc);
      total++;
      if (!found || ins[7:0] !== ops[i] || len !== want_len[i] || ipc !== model_pc) begin
        bad++;
        $display("FAIL length_%h: found=%b opcode=%h len=%0d pc=%h, want len=%0d pc=%h",
                 ops[i], found, ins[7:0], len, ipc, want_len[i], model_pc);
      end
      model_pc = model_pc + 16'(want_len[i]);
    end
  endtask

  task automatic test_backpressure();
    bit found; int cyc; logic [23:0] ins; logic [1:0] len; logic [15:0] ipc;
    logic [23:0] r_ins; logic [1:0] r_len; logic [15:0] r_pc;
    bit ok;
    wait_valid(20, found, cyc);
    r_ins = instr_o; r_len = instr_len_o; r_pc = instr_pc_o;
    ok = found;
    for (int i = 0; i < 5; i++) begin
      step();
      if (instr_valid_o !== 1'b1 || instr_o !== r_ins || instr_len_o !== r_len ||
          instr_pc_o !== r_pc || mem_we_o !== 1'b0 || mem_addr_o !== r_pc) ok = 1'b0;
    end
    total++;
    if (!ok || r_pc !== model_pc || r_ins !== ref_instr(model_pc)) begin
      bad++;
      $display("FAIL backpressure_hold: valid=%b instr=%h pc=%h addr=%h, want instr=%h pc=%h held",
               instr_valid_o, instr_o, instr_pc_o, mem_addr_o, ref_instr(model_pc), model_pc);
    end
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    total++;
    if (instr_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_accept: valid=%b, want 0 after handshake", instr_valid_o);
    end
    model_pc = model_pc + 16'(ref_len(mem[model_pc]));
    take(found, cyc, ins, len, ipc);
    total++;
    if (!found || ipc !== model_pc) begin
      bad++;
      $display("FAIL backpressure_next_pc: found=%b pc=%h, want %h", found, ipc, model_pc);
    end
    model_pc = model_pc + 16'(ref_len(mem[model_pc]));
  endtask

  task automatic test_store();
    bit found; int cyc; logic [23:0] ins; logic [1:0] len; logic [15:0] ipc;
    // Store issued in S_REQ delays the fetch by one cycle.
    st_req_i = 1'b1; st_addr_i = 16'h0040; st_data_i = 8'hA5;
    #1;
    total++;
    if (mem_we_o !== 1'b1 || mem_addr_o !== 16'h0040 || mem_data_o !== 8'hA5 || st_gnt_o !== 1'b1) begin
      bad++;
      $display("FAIL store_in_req: we=%b addr=%h data=%h gnt=%b, want 1 0040 a5 1",
               mem_we_o, mem_addr_o, mem_data_o, st_gnt_o);
    end
    step();
    st_req_i = 1'b0;
    take(found, cyc, ins, len, ipc);
    total++;
    if (!found || cyc !== 3 || ipc !== model_pc || mem[16'h0040] !== 8'hA5) begin
      bad++;
      $display("FAIL store_fetch_delay: found=%b cycle=%0d pc=%h mem40=%h, want cycle=3 pc=%h mem40=a5",
               found, cyc, ipc, mem[16'h0040], model_pc);
    end
    model_pc = model_pc + 16'(ref_len(mem[model_pc]));
    // Store requested while the read response is pending waits for S_VALID.
    step();
    st_req_i = 1'b1; st_addr_i = 16'h0041; st_data_i = 8'h5A;
    #1;
    total++;
    if (st_gnt_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== model_pc) begin
      bad++;
      $display("FAIL store_in_rsp: gnt=%b we=%b addr=%h, want 0 0 %h", st_gnt_o, mem_we_o, mem_addr_o, model_pc);
    end
    step();
    total++;
    if (instr_valid_o !== 1'b1 || st_gnt_o !== 1'b1 || mem_we_o !== 1'b1 ||
        mem_addr_o !== 16'h0041 || instr_o !== ref_instr(model_pc)) begin
      bad++;
      $display("FAIL store_in_valid: valid=%b gnt=%b we=%b addr=%h instr=%h, want 1 1 1 0041 %h",
               instr_valid_o, st_gnt_o, mem_we_o, mem_addr_o, instr_o, ref_instr(model_pc));
    end
    st_req_i = 1'b0;
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    model_pc = model_pc + 16'(ref_len(mem[model_pc]));
  endtask

  task automatic test_redirect();
    bit found; int cyc; logic [23:0] ins; logic [1:0] len; logic [15:0] ipc;
    step();  // now in S_RSP for the old PC
    do_redirect(16'h0100);
    take(found, cyc, ins, len, ipc);
    total++;
    if (!found || ipc !== 16'h0100 || ins !== ref_instr(16'h0100)) begin
      bad++;
      $display("FAIL redirect_in_rsp: found=%b pc=%h instr=%h, want pc=0100 instr=%h",
               found, ipc, ins, ref_instr(16'h0100));
    end
    wait_valid(20, found, cyc);
    instr_ready_i = 1'b1;
    do_redirect(16'h0100);
    instr_ready_i = 1'b0;
    total++;
    if (!found || instr_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL redirect_handshake_drop: found=%b valid=%b, want valid=0", found, instr_valid_o);
    end
    take(found, cyc, ins, len, ipc);
    total++;
    if (!found || ipc !== 16'h0100) begin
      bad++;
      $display("FAIL redirect_handshake_pc: found=%b pc=%h, want 0100", found, ipc);
    end
    model_pc = 16'h0100 + 16'(ref_len(mem[16'h0100]));
  endtask

  task automatic test_wrap();
    bit found; int cyc; logic [23:0] ins; logic [1:0] len; logic [15:0] ipc;
    mem[16'hFFFE] <= 8'hAD; mem[16'hFFFF] <= 8'h34; mem[16'h0000] <= 8'h12;
    do_redirect(16'hFFFE);
    take(found, cyc, ins, len, ipc);
    total++;
    if (!found || ins !== 24'h1234AD || len !== 2'd3 || ipc !== 16'hFFFE) begin
      bad++;
      $display("FAIL wrap_fetch: found=%b instr=%h len=%0d pc=%h, want 1234ad 3 fffe", found, ins, len, ipc);
    end
    take(found, cyc, ins, len, ipc);
    total++;
    if (!found || ipc !== 16'h0001) begin
      bad++;
      $display("FAIL wrap_next_pc: found=%b pc=%h, want 0001", found, ipc);
    end
  endtask

  task automatic test_reset_mid();
    bit found; int cyc; logic [23:0] ins; logic [1:0] len; logic [15:0] ipc;
    wait_valid(20, found, cyc);
    rst_i = 1'b1;
    #1;
    total++;
    if (!found || instr_valid_o !== 1'b0 || instr_o !== 24'h0 || instr_pc_o !== 16'h0 || instr_len_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid: found=%b valid=%b instr=%h pc=%h len=%0d, want all zero",
               found, instr_valid_o, instr_o, instr_pc_o, instr_len_o);
    end
    step();
    rst_i = 1'b0;
    take(found, cyc, ins, len, ipc);
    total++;
    if (!found || ipc !== 16'h0000 || ins !== ref_instr(16'h0000)) begin
      bad++;
      $display("FAIL reset_mid_refetch: found=%b pc=%h instr=%h, want pc=0000 instr=%h",
               found, ipc, ins, ref_instr(16'h0000));
    end
  endtask

  task automatic test_random();
    int hs = 0;
    int cyc = 0;
    bit gnt_prev = 1'b0;
    logic [1:0] want_len;
    do_redirect(16'h3000);
    while (hs < 150 && cyc < 6000) begin
      @(negedge clk_i);
      if (gnt_prev) st_req_i = 1'b0;
      if (!st_req_i && $urandom_range(5) == 0) begin
        st_req_i  = 1'b1;
        st_addr_i = 16'h8000 | 16'($urandom_range(255));
        st_data_i = 8'($urandom);
      end
      instr_ready_i = ($urandom_range(2) != 0);
      redirect_i    = ($urandom_range(39) == 0);
      redirect_pc_i = 16'h1000 + 16'($urandom_range(16'h1FFF));
      #1;
      want_len = ref_len(mem[model_pc]);
      if (instr_valid_o) begin
        total++;
        if (instr_o !== ref_instr(model_pc) || instr_len_o !== want_len || instr_pc_o !== model_pc) begin
          bad++;
          $display("FAIL random_instr: instr=%h len=%0d pc=%h, want %h %0d %h",
                   instr_o, instr_len_o, instr_pc_o, ref_instr(model_pc), want_len, model_pc);
        end
      end
      if (st_gnt_o) begin
        total++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== st_addr_i || mem_data_o !== st_data_i) begin
          bad++;
          $display("FAIL random_store: we=%b addr=%h data=%h, want 1 %h %h",
                   mem_we_o, mem_addr_o, mem_data_o, st_addr_i, st_data_i);
        end
      end
      gnt_prev = st_gnt_o;
      if (instr_valid_o && instr_ready_i) hs++;
      if (redirect_i) model_pc = redirect_pc_i;
      else if (instr_valid_o && instr_ready_i) model_pc = model_pc + 16'(want_len);
      cyc++;
    end
    total++;
    if (hs < 150) begin
      bad++;
      $display("FAIL random_progress: handshakes=%0d in %0d cycles, want 150", hs, cyc);
    end
    @(negedge clk_i);
    st_req_i = 1'b0; instr_ready_i = 1'b0; redirect_i = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
    step();
    test_reset();
    test_lengths();
    test_backpressure();
    test_store();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
